// File: rtl/gpu_pkg.sv
// Shared GPU frame-buffer constants and the scanout state encoding.
package gpu_pkg;

    localparam int FB_WIDTH  = 64;
    localparam int FB_HEIGHT = 64;
    localparam int FB_WORD_W = 8;

    typedef enum logic [1:0] {
        SO_IDLE,
        SO_LOAD,
        SO_STREAM,
        SO_DONE
    } scanout_state_t;

endpackage

// File: rtl/frame_scan_counter.sv
// Row/word position counter for frame scanout. Clear has priority over advance.
// Wraps word at the end of each row and everything at the end of the frame.
module frame_scan_counter
    import gpu_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int WORD_W = FB_WORD_W,
    localparam int WPR   = WIDTH / WORD_W,
    localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1,
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [RW-1:0] row_o,
    output logic [WW-1:0] word_o,
    output logic          last_word_o,
    output logic          last_frame_o
);

    logic [RW-1:0] row_q, row_d;
    logic [WW-1:0] word_q, word_d;

    assign last_word_o  = (word_q == WW'(WPR - 1));
    assign last_frame_o = last_word_o && (row_q == RW'(HEIGHT - 1));
    assign row_o        = row_q;
    assign word_o       = word_q;

    // Next position: step word, roll into next row, roll frame back to origin.
    always_comb begin
        row_d  = row_q;
        word_d = word_q;
        if (clear_i) begin
            row_d  = '0;
            word_d = '0;
        end else if (advance_i) begin
            if (last_word_o) begin
                word_d = '0;
                row_d  = last_frame_o ? '0 : row_q + 1'b1;
            end else begin
                word_d = word_q + 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_q  <= '0;
            word_q <= '0;
        end else begin
            row_q  <= row_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// Frame scanout: snapshots the rasterizer's 1-bit frame on start and streams it
// row-major as WORD_W-pixel words over valid/ready.
module frame_scanout
    import gpu_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int WORD_W = FB_WORD_W,
    localparam int WPR   = WIDTH / WORD_W,
    localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1,
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int NPIX  = WIDTH * HEIGHT,
    localparam int AW    = $clog2(NPIX)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [NPIX-1:0]   frame_in,
    input  logic              start,
    input  logic              abort,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic [RW-1:0]     out_row,
    output logic              busy,
    output logic              done
);

    scanout_state_t    state_q, state_d;
    logic [NPIX-1:0]   snap_q, snap_d;
    logic [RW-1:0]     row;
    logic [WW-1:0]     word;
    logic              last_word, last_frame;
    logic              xfer, cnt_clear, cnt_adv;
    logic [AW-1:0]     base;

    assign out_valid = (state_q == SO_STREAM);
    assign xfer      = out_valid & out_ready;
    // Abort beats a coincident transfer; counters sit at origin outside STREAM.
    assign cnt_adv   = xfer & ~abort;
    assign cnt_clear = abort | (state_q != SO_STREAM);

    frame_scan_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .WORD_W (WORD_W)
    ) u_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear_i      (cnt_clear),
        .advance_i    (cnt_adv),
        .row_o        (row),
        .word_o       (word),
        .last_word_o  (last_word),
        .last_frame_o (last_frame)
    );

    // FSM next state and snapshot capture; abort overrides everything.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        case (state_q)
            SO_IDLE: begin
                if (start) begin
                    state_d = SO_LOAD;
                    snap_d  = frame_in;
                end
            end
            SO_LOAD:   state_d = SO_STREAM;
            SO_STREAM: if (xfer && last_frame) state_d = SO_DONE;
            SO_DONE:   state_d = SO_IDLE;
            default:   state_d = SO_IDLE;
        endcase
        if (abort) begin
            state_d = SO_IDLE;
            snap_d  = snap_q;
        end
    end

    // State and snapshot registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= SO_IDLE;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
        end
    end

    // Output mux: word select from the snapshot, everything forced low when not valid.
    always_comb begin
        base     = AW'(row) * AW'(WIDTH) + AW'(word) * AW'(WORD_W);
        out_data = out_valid ? snap_q[base +: WORD_W] : '0;
        out_sof  = out_valid && (row == '0) && (word == '0);
        out_eol  = out_valid && last_word;
        out_row  = out_valid ? row : '0;
        busy     = (state_q == SO_LOAD) || (state_q == SO_STREAM);
        done     = (state_q == SO_DONE);
    end

endmodule

// File: tb/tb_frame_scanout.sv
// Directed bench for frame_scanout: one task per scenario, inline checks.
module tb_frame_scanout;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int WD = 8;
    localparam int NW = H * W / WD;

    logic            clk = 1'b0;
    logic            n_rst;
    logic [W*H-1:0]  frame_in;
    logic            start, abort, out_ready;
    logic [WD-1:0]   out_data;
    logic            out_valid, out_sof, out_eol, busy, done;
    logic [5:0]      out_row;

    int tot = 0;
    int bad = 0;

    logic [7:0] got_data [NW];
    logic       got_sof  [NW];
    logic       got_eol  [NW];
    logic [5:0] got_row  [NW];
    int n_got, done_cnt, done_k, first_valid_k, stable_err, abort_valid, abort_busy;

    always #5 clk = ~clk;

    frame_scanout dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .frame_in  (frame_in),
        .start     (start),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_row   (out_row),
        .busy      (busy),
        .done      (done)
    );

    // Pulse start, then collect accepted words cycle by cycle. k counts cycles after
    // the edge that samples start (k=1 is LOAD). Optional mid-stream start/frame
    // change at inject_k and abort at abort_k.
    task automatic run_frame(input bit rand_ready, input int inject_k, input int abort_k);
        logic       pv, pr, ps, pe;
        logic [7:0] pd;
        logic [5:0] prw;
        n_got = 0; done_cnt = 0; done_k = -1; first_valid_k = -1;
        stable_err = 0; abort_valid = -1; abort_busy = -1;
        pv = 0; pr = 0; ps = 0; pe = 0; pd = '0; prw = '0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 1; k < 3000; k++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == inject_k) begin frame_in = '1; start = 1'b1; end
            if (k == inject_k + 1) start = 1'b0;
            abort = (k == abort_k);
            @(negedge clk);
            if (abort_k > 0 && k == abort_k + 1) begin
                abort_valid = int'(out_valid);
                abort_busy  = int'(busy);
            end
            if (pv && !pr && (!out_valid || out_data !== pd || out_sof !== ps ||
                              out_eol !== pe || out_row !== prw))
                stable_err++;
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (out_valid && out_ready && !abort && n_got < NW) begin
                got_data[n_got] = out_data;
                got_sof[n_got]  = out_sof;
                got_eol[n_got]  = out_eol;
                got_row[n_got]  = out_row;
                n_got++;
            end
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            ps = out_sof; pe = out_eol; prw = out_row;
            @(posedge clk); #1;
            if (done_k > 0 && k >= done_k + 3) break;
            if (abort_k > 0 && k >= abort_k + 20) break;
        end
        out_ready = 1'b1;
        abort     = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; frame_in = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        tot++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        tot++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        tot++; if ({out_data, out_sof, out_eol, out_row} !== '0) begin
            bad++; $display("FAIL rst_outs: data=%h sof=%b eol=%b row=%0d want all 0",
                            out_data, out_sof, out_eol, out_row);
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_frame();
        int e_data, e_sof, e_eol, e_row;
        e_data = 0; e_sof = 0; e_eol = 0; e_row = 0;
        frame_in = '0;
        run_frame(1'b0, 0, 0);
        for (int i = 0; i < n_got; i++) begin
            if (got_data[i] !== 8'h00) e_data++;
            if (got_sof[i] !== (i == 0)) e_sof++;
            if (got_eol[i] !== ((i % 8) == 7)) e_eol++;
            if (got_row[i] !== 6'(i / 8)) e_row++;
        end
        tot++; if (n_got !== NW) begin bad++; $display("FAIL z_count: got %0d want %0d", n_got, NW); end
        tot++; if (e_data != 0) begin bad++; $display("FAIL z_data: %0d nonzero words want 0", e_data); end
        tot++; if (e_sof != 0) begin bad++; $display("FAIL z_sof: %0d bad sof flags want 0", e_sof); end
        tot++; if (e_eol != 0) begin bad++; $display("FAIL z_eol: %0d bad eol flags want 0", e_eol); end
        tot++; if (e_row != 0) begin bad++; $display("FAIL z_row: %0d bad rows want 0", e_row); end
        tot++; if (first_valid_k != 2) begin bad++; $display("FAIL z_first_valid: got k=%0d want 2", first_valid_k); end
        // Start cycle k=0 through done cycle k=514 inclusive is 515 cycles.
        tot++; if (done_k != 514) begin bad++; $display("FAIL z_done_time: got k=%0d want 514", done_k); end
        tot++; if (done_cnt != 1) begin bad++; $display("FAIL z_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_corners(input bit rand_ready, input string tag);
        int e_mid;
        e_mid = 0;
        frame_in = '0;
        frame_in[0] = 1'b1;
        frame_in[63 * W + 63] = 1'b1;
        run_frame(rand_ready, 0, 0);
        for (int i = 1; i < NW - 1; i++) if (got_data[i] !== 8'h00) e_mid++;
        tot++; if (n_got !== NW) begin bad++; $display("FAIL %s_count: got %0d want %0d", tag, n_got, NW); end
        tot++; if (got_data[0] !== 8'h01) begin bad++; $display("FAIL %s_w0: got %h want 01", tag, got_data[0]); end
        tot++; if (got_data[NW-1] !== 8'h80) begin bad++; $display("FAIL %s_w511: got %h want 80", tag, got_data[NW-1]); end
        tot++; if (got_row[NW-1] !== 6'd63) begin bad++; $display("FAIL %s_row511: got %0d want 63", tag, got_row[NW-1]); end
        tot++; if (got_eol[NW-1] !== 1'b1) begin bad++; $display("FAIL %s_eol511: got %b want 1", tag, got_eol[NW-1]); end
        tot++; if (e_mid != 0) begin bad++; $display("FAIL %s_mid: %0d nonzero words want 0", tag, e_mid); end
        tot++; if (stable_err != 0) begin bad++; $display("FAIL %s_stall_hold: %0d unstable cycles want 0", tag, stable_err); end
        tot++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_cnt: got %0d want 1", tag, done_cnt); end
    endtask

    task automatic test_diagonal();
        int e_diag;
        e_diag = 0;
        frame_in = '0;
        for (int y = 0; y < 8; y++) frame_in[y * W + y] = 1'b1;
        run_frame(1'b0, 0, 0);
        for (int y = 0; y < 8; y++) if (got_data[y * 8] !== 8'(1 << y)) e_diag++;
        tot++; if (e_diag != 0) begin bad++; $display("FAIL diag_words: %0d wrong row-start words want 0", e_diag); end
        tot++; if (got_data[7 * 8] !== 8'h80) begin bad++; $display("FAIL diag_row7: got %h want 80", got_data[56]); end
        tot++; if (got_data[1] !== 8'h00) begin bad++; $display("FAIL diag_w1: got %h want 00", got_data[1]); end
    endtask

    task automatic test_ignore_start();
        int e_diag;
        e_diag = 0;
        frame_in = '0;
        for (int y = 0; y < 8; y++) frame_in[y * W + y] = 1'b1;
        run_frame(1'b0, 50, 0);
        for (int y = 0; y < 8; y++) if (got_data[y * 8] !== 8'(1 << y)) e_diag++;
        tot++; if (e_diag != 0) begin bad++; $display("FAIL ign_diag: %0d wrong words want 0", e_diag); end
        tot++; if (got_data[100] !== 8'h00) begin bad++; $display("FAIL ign_w100: got %h want 00", got_data[100]); end
        tot++; if (n_got !== NW) begin bad++; $display("FAIL ign_count: got %0d want %0d", n_got, NW); end
        tot++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
        frame_in = '0;
    endtask

    task automatic test_abort_reset();
        frame_in = '1;
        // Abort while word 100 is on the bus: words 0..99 transferred.
        run_frame(1'b0, 0, 102);
        tot++; if (n_got != 100) begin bad++; $display("FAIL ab_count: got %0d want 100", n_got); end
        tot++; if (abort_valid != 0) begin bad++; $display("FAIL ab_valid: got %0d want 0", abort_valid); end
        tot++; if (abort_busy != 0) begin bad++; $display("FAIL ab_busy: got %0d want 0", abort_busy); end
        tot++; if (done_cnt != 0) begin bad++; $display("FAIL ab_done: got %0d want 0", done_cnt); end
        run_frame(1'b0, 0, 0);
        tot++; if (got_sof[0] !== 1'b1) begin bad++; $display("FAIL ab_resof: got %b want 1", got_sof[0]); end
        tot++; if (got_data[0] !== 8'hFF) begin bad++; $display("FAIL ab_rew0: got %h want ff", got_data[0]); end
        tot++; if (n_got !== NW) begin bad++; $display("FAIL ab_recount: got %0d want %0d", n_got, NW); end
        // Asynchronous reset in the middle of a frame.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        tot++; if (!(out_valid === 1'b1 && out_data === 8'hFF)) begin
            bad++; $display("FAIL rs_pre: valid=%b data=%h want 1/ff", out_valid, out_data);
        end
        n_rst = 1'b0;
        #1;
        tot++; if ({out_valid, busy, done, out_sof, out_eol} !== 5'b0) begin
            bad++; $display("FAIL rs_flags: v=%b b=%b d=%b s=%b e=%b want 0", out_valid, busy, done, out_sof, out_eol);
        end
        tot++; if ({out_data, out_row} !== '0) begin
            bad++; $display("FAIL rs_data: data=%h row=%0d want 0", out_data, out_row);
        end
        @(negedge clk); n_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tot++; if ({out_valid, busy, done} !== 3'b0) begin
            bad++; $display("FAIL rs_idle: v=%b b=%b d=%b want 0", out_valid, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_corners(1'b0, "px");
        test_diagonal();
        test_corners(1'b1, "stall");
        test_ignore_start();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
